imm_ext_arbiter: RTL and testbench

//  Shares one registered immediate-extension unit among NREQ requesters (decode, branch

---
 rtl/imm_ext_pkg.sv | 42 ++++
 rtl/imm_ext_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/imm_ext_arbiter.sv | 93 +++++++++
 tb/tb_imm_ext_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types and the immediate-extension function
package imm_ext_pkg;

   localparam int MODE_W   = 2;
   localparam int MAX_IW   = 32;
   localparam int MAX_OW   = 64;

   typedef enum logic [MODE_W-1:0] {
      SEXT = 2'b00,
      ZEXT = 2'b01,
      LUI  = 2'b10,
      RSVD = 2'b11
   } ext_mode_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Mask arithmetic instead of variable bit selects; iw/ow are elaboration constants.
   function automatic logic [MAX_OW-1:0] ext_fn(input logic [MAX_IW-1:0] imm,
                                                input ext_mode_t mode,
                                                input int iw,
                                                input int ow);
      logic [MAX_OW-1:0] imm64;
      logic [MAX_OW-1:0] lmask;
      logic [MAX_OW-1:0] omask;
      logic [MAX_OW-1:0] r;
      logic              sign;
      imm64 = {{(MAX_OW-MAX_IW){1'b0}}, imm};
      lmask = (64'd1 << iw) - 64'd1;
      omask = (64'd1 << ow) - 64'd1;
      sign  = |(imm64 & (64'd1 << (iw - 1)));
      case (mode)
         ZEXT:    r = imm64 & lmask;
         LUI:     r = (imm64 & lmask) << iw;
         default: r = (imm64 & lmask) | (sign ? ~lmask : 64'd0);
      endcase
      return r & omask;
   endfunction

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// rtl/imm_ext_arbiter_if.sv - requester and response channel bundle
interface imm_ext_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IW   = 16,
   parameter int OW   = 32
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*IW-1:0] req_imm;
   logic [NREQ*2-1:0]  req_mode;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [OW-1:0]      rsp_data;
   logic [IDW-1:0]     rsp_id;

   modport master (
      output req_valid, req_imm, req_mode, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_imm, req_mode, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  grant_idx_o,
   output logic            any_o
);

   always_comb begin
      int idx;
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      idx         = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_i) + k) % NREQ;
         if (!any_o && req_i[idx]) begin
            any_o        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - round-robin shared immediate extender with one-deep response register
module imm_ext_arbiter
   import imm_ext_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = 16,
   parameter int OW   = 32,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   imm_ext_arbiter_if.slave ext_if,
   output logic [7:0]       busy_cnt
);

   state_t          state_q, state_d;
   logic [OW-1:0]   data_q, data_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [7:0]      busy_q, busy_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic            any;
   logic            slot_free;
   logic            accept;
   logic [IW-1:0]   imm_sel;
   ext_mode_t       mode_sel;
   logic [OW-1:0]   ext_val;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i       (ext_if.req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_o       (any)
   );

   assign slot_free        = (state_q == EMPTY) | ext_if.rsp_ready;
   assign accept           = any & slot_free;
   assign ext_if.req_ready = slot_free ? grant : '0;

   assign imm_sel  = ext_if.req_imm[int'(grant_idx)*IW +: IW];
   assign mode_sel = ext_mode_t'(ext_if.req_mode[int'(grant_idx)*MODE_W +: MODE_W]);
   assign ext_val  = OW'(ext_fn(MAX_IW'(imm_sel), mode_sel, IW, OW));

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      // A stalled FULL slot holds everything; otherwise an accept always reloads.
      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (ext_if.rsp_ready && !accept) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
      if (accept) begin
         data_d = ext_val;
         id_d   = grant_idx;
         ptr_d  = IDW'((int'(grant_idx) + 1) % NREQ);
      end
      if (state_q == FULL && !ext_if.rsp_ready && busy_q != 8'hFF)
         busy_d = busy_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign ext_if.rsp_valid = (state_q == FULL);
   assign ext_if.rsp_data  = data_q;
   assign ext_if.rsp_id    = id_q;
   assign busy_cnt         = busy_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb/tb_imm_ext_arbiter.sv - directed self-checking bench for imm_ext_arbiter
module tb_imm_ext_arbiter;

   localparam int NREQ = 4;
   localparam int IW   = 16;
   localparam int OW   = 32;

   logic       clk;
   logic       rst_n;
   logic [7:0] busy_cnt;
   int         n_checks;
   int         n_fail;

   imm_ext_arbiter_if #(.NREQ(NREQ), .IW(IW), .OW(OW)) ext_if ();

   imm_ext_arbiter #(.NREQ(NREQ), .IW(IW), .OW(OW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ext_if   (ext_if),
      .busy_cnt (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [15:0] imm, input logic [1:0] mode);
      ext_if.req_imm[i*IW +: IW] = imm;
      ext_if.req_mode[i*2 +: 2]  = mode;
   endtask

   initial begin
      logic [15:0] mode_imm [5];
      logic [1:0]  mode_sel [5];
      logic [31:0] mode_exp [5];
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      ext_if.req_valid = '0;
      ext_if.req_imm   = '0;
      ext_if.req_mode  = '0;
      ext_if.rsp_ready = 1'b1;
      #12;
      check("rst_rsp_valid", 64'(ext_if.rsp_valid), 64'd0);
      check("rst_rsp_data",  64'(ext_if.rsp_data),  64'd0);
      check("rst_rsp_id",    64'(ext_if.rsp_id),    64'd0);
      check("rst_busy",      64'(busy_cnt),         64'd0);
      rst_n = 1'b1;
      tick();

      // Extension modes, requester 0 alone, back-to-back
      mode_imm = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF};
      mode_sel = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      mode_exp = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFF8001, 32'h00007FFF};
      ext_if.req_valid = 4'b0001;
      for (int m = 0; m < 5; m++) begin
         set_req(0, mode_imm[m], mode_sel[m]);
         #1;
         check("mode_req_ready", 64'(ext_if.req_ready), 64'b0001);
         tick();
         check("mode_rsp_valid", 64'(ext_if.rsp_valid), 64'd1);
         check("mode_rsp_data",  64'(ext_if.rsp_data),  64'(mode_exp[m]));
         check("mode_rsp_id",    64'(ext_if.rsp_id),    64'd0);
      end
      ext_if.req_valid = '0;
      tick();
      check("idle_rsp_valid", 64'(ext_if.rsp_valid), 64'd0);

      // Round-robin from a fresh pointer
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 16'h0010 + 16'(i), 2'b01);
      ext_if.req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("rr_req_ready", 64'(ext_if.req_ready), 64'(4'b0001 << (c % 4)));
         tick();
         check("rr_rsp_id",   64'(ext_if.rsp_id),   64'(c % 4));
         check("rr_rsp_data", 64'(ext_if.rsp_data), 64'(32'h10 + 32'(c % 4)));
      end

      // Backpressure with requester 0's response pending; pointer is at 1
      ext_if.rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_req_ready", 64'(ext_if.req_ready), 64'd0);
         tick();
         check("bp_rsp_valid", 64'(ext_if.rsp_valid), 64'd1);
         check("bp_rsp_id",    64'(ext_if.rsp_id),    64'd0);
         check("bp_rsp_data",  64'(ext_if.rsp_data),  64'h10);
      end
      check("bp_busy", 64'(busy_cnt), 64'd5);
      ext_if.rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(ext_if.req_ready), 64'b0010);
      tick();
      check("bp_release_id", 64'(ext_if.rsp_id), 64'd1);

      // Move pointer to 3, then wrap and skip
      ext_if.req_valid = 4'b0100;
      tick();
      check("wrap_pre_id", 64'(ext_if.rsp_id), 64'd2);
      ext_if.req_valid = 4'b0010;
      #1;
      check("wrap_req_ready", 64'(ext_if.req_ready), 64'b0010);
      tick();
      check("wrap_rsp_id", 64'(ext_if.rsp_id), 64'd1);
      ext_if.req_valid = 4'b1001;
      #1;
      check("skip_req_ready", 64'(ext_if.req_ready), 64'b1000);
      tick();
      check("skip_rsp_id",   64'(ext_if.rsp_id),   64'd3);
      check("skip_rsp_data", 64'(ext_if.rsp_data), 64'h13);
      ext_if.req_valid = '0;
      tick();
      check("drain_rsp_valid", 64'(ext_if.rsp_valid), 64'd0);

      // Saturation of the stall counter
      ext_if.req_valid = 4'b0001;
      tick();
      ext_if.rsp_ready = 1'b0;
      repeat (300) tick();
      check("sat_busy",      64'(busy_cnt),         64'd255);
      check("sat_rsp_valid", 64'(ext_if.rsp_valid), 64'd1);

      // Asynchronous reset with a response pending
      ext_if.req_valid = 4'b1111;
      rst_n = 1'b0;
      #2;
      check("arst_rsp_valid", 64'(ext_if.rsp_valid), 64'd0);
      check("arst_busy",      64'(busy_cnt),         64'd0);
      rst_n = 1'b1;
      ext_if.rsp_ready = 1'b1;
      #1;
      check("arst_req_ready", 64'(ext_if.req_ready), 64'b0001);
      tick();
      check("arst_rsp_id",   64'(ext_if.rsp_id),   64'd0);
      check("arst_rsp_data", 64'(ext_if.rsp_data), 64'h10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
